// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit and its HI/LO registers.
// start is taken only at an edge where busy is low; done pulses for one cycle as hi/lo take the new result.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32 radix-2 iterations on operand magnitudes, then one sign-fix cycle.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module mul_div_unit (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic        dz_q, dz_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic        start_signed;
  logic [31:0] mag_a, mag_b;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  logic        res_signed;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [63:0] res;

  assign accept       = (state_q == IDLE) && bus.start;
  assign start_signed = ~bus.op[0];
  assign mag_a        = (start_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign mag_b        = (start_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = done_q;
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.dbg_state = state_q;
  end

  // Multiply step: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide step: acc holds {partial remainder, dividend bits / quotient bits}.
  // The remainder stays below the divisor, so the shifted value minus divisor fits in 32 bits.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[31:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};

  assign res_signed = ~op_q[0];
  assign prod_fix   = (res_signed && (neg_a_q ^ neg_b_q)) ? (64'd0 - acc_q) : acc_q;
  assign quo_fix    = (res_signed && (neg_a_q ^ neg_b_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix    = (res_signed && neg_a_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // A zero divisor leaves the dividend in the remainder, so only the quotient needs forcing.
  assign res = op_q[1] ? {rem_fix, (dz_q ? 32'hFFFF_FFFF : quo_fix)} : prod_fix;

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    if (accept) begin
      cnt_d   = 5'd0;
      op_d    = bus.op;
      neg_a_d = bus.a[31];
      neg_b_d = bus.b[31];
      dz_d    = (bus.b == 32'd0);
      opnd_d  = mag_b;
      acc_d   = {32'd0, mag_a};
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = op_q[1] ? div_next : mul_next;
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (state_q == FIX) begin
      hi_d   = res[63:32];
      lo_d   = res[31:0];
      done_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  in  1  rising-edge clock for all state.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request to begin an operation, sampled on a clk edge.
REQ-005 Port: op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: a  in  32  operand rs (multiplicand or dividend).
REQ-007 Port: b  in  32  operand rt (multiplier or divisor).
REQ-008 Port: hi_we  in  1  MTHI write strobe.
REQ-009 Port: lo_we  in  1  MTLO write strobe.
REQ-010 Port: wdata  in  32  MTHI/MTLO write data.
REQ-011 Port: busy  out  1  operation in progress.
REQ-012 Port: done  out  1  one-cycle completion pulse.
REQ-013 Port: hi  out  32  HI register: product[63:32] or remainder.
REQ-014 Port: lo  out  32  LO register: product[31:0] or quotient.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIX; only IDLE accepts start.
REQ-016 Accept: start=1 in IDLE at edge E0 -> latch op, a and b; clear the iteration counter; enter RUN.
REQ-017 Ignore: start=1 while busy=1 SHALL be ignored with no effect on operands or timing.
REQ-018 RUN SHALL perform exactly 32 iterations, one per clock, counter 0..31; after iteration 31 enter FIX.
REQ-019 Multiply algorithm: radix-2 shift-add on magnitudes, using a 64-bit accumulator.
REQ-020 Divide algorithm: restoring shift-subtract on magnitudes, 1 quotient bit per iteration.
REQ-021 Signed ops (MULT, DIV): take operand magnitudes at accept; FIX applies sign correction.
REQ-022 Signed product sign: negate the 64-bit product if sign(a) XOR sign(b).
REQ-023 Signed quotient: truncates toward zero, negated if sign(a) XOR sign(b).
REQ-024 Signed remainder: takes the sign of the dividend.
REQ-025 FIX SHALL last one cycle; at edge E33, hi and lo update, busy falls to 0, done=1 for exactly one cycle, and the state returns to IDLE.
REQ-026 busy SHALL be 1 from after E0 until E33, i.e. 33 cycles in total.
REQ-027 Divide by zero (b=0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a, normal latency, no flag.
REQ-028 Signed overflow (DIV, a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
REQ-029 MULT overflow case: 32'h80000000 * 32'h80000000 SHALL produce hi=32'h40000000, lo=0.
REQ-030 In IDLE, hi_we/lo_we SHALL load wdata into hi/lo at the next edge; hi_we and lo_we may act in the same cycle.
REQ-031 While busy=1, hi_we/lo_we SHALL be ignored.
REQ-032 When start and hi_we/lo_we are both asserted in IDLE, both SHALL take effect; the written value is later overwritten at E33.
REQ-033 hi and lo SHALL hold their values at all times other than a completion edge, an IDLE write, or reset.
REQ-034 Operand inputs SHALL be don't-care after E0.

Reset
REQ-035 On rst_n=0, immediately and independent of clk: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-036 Reset asserted mid-operation SHALL abort the operation with no done pulse and no partial hi/lo update.
REQ-037 After rst_n deasserts, the first start SHALL be accepted at the first clk edge.

Verification
REQ-038 MULTU: a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done at E33, hi=32'hFFFFFFFE, lo=32'h00000001, busy high for 33 cycles.
REQ-039 MULT and DIV: MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-040 DIVU and DIV edge cases: DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-041 start pulses at E5 and E20 after accept at E0 -> both ignored, single done at E33; a second start at the done cycle is accepted.
REQ-042 MTHI/MTLO: hi_we in IDLE, wdata=32'h12345678 -> hi=32'h12345678 next cycle; lo_we during busy -> lo unchanged until result.
REQ-043 Mid-operation reset: rst_n=0 at cycle 10 of RUN -> busy=0, hi=lo=0 asynchronously, no done pulse; a new MULTU afterwards completes normally.
